regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_pkg.sv | 17 +
 rtl/piso_shift.sv | 30 +++
 rtl/regfile_reader.sv | 112 +++++++++++
 tb/tb_regfile_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared parameter defaults and FSM state encoding for the register-file dump reader.
// Latency: none (declarations only).
// Backpressure: not applicable.
package regfile_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB presented first.
// Latency: load and shift take effect on the next rising clk.
// Backpressure: holds its contents whenever neither load nor shift is asserted.
module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg;

    // Load has priority; a shift moves the next bit into the MSB position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[W-1];

endmodule

// File: rtl/regfile_reader.sv
// Walks DEPTH register-file entries and streams each word out serially, MSB first.
// Latency: first bit valid one cycle after start; each word costs DATA_W+1 cycles at full rate.
// Backpressure: sout/sout_valid hold while sout_ready is low; nothing is dropped or repeated.
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              busy,
    output logic              done
);

    // Counters sized to exactly cover their range so they cannot run past the end.
    localparam int AW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [BW-1:0] bitcnt, bitcnt_nxt;
    logic          load;
    logic          xfer;
    logic          shift_msb;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr   <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            bitcnt <= bitcnt_nxt;
        end
    end

    // Next-state, counter updates and per-state outputs.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        bitcnt_nxt = bitcnt;
        load       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_FETCH;
                    addr_nxt   = '0;
                    bitcnt_nxt = '0;
                end
            end
            ST_FETCH: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                sout_valid = 1'b1;
                if (sout_ready) begin
                    if (bitcnt == LAST_BIT) begin
                        bitcnt_nxt = '0;
                        if (addr < LAST_ADDR) begin
                            addr_nxt  = addr + 1'b1;
                            state_nxt = ST_FETCH;
                        end else begin
                            // Address stays on the last entry until the next start.
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        bitcnt_nxt = bitcnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign xfer  = sout_valid & sout_ready;
    assign busy  = (state != ST_IDLE);
    assign raddr = ADDR_W'(addr);
    assign sout  = sout_valid & shift_msb;

    piso_shift #(
        .W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (xfer),
        .din   (rdata),
        .msb   (shift_msb)
    );

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: stimulus pushes the expected serial stream, a monitor checks it.
// Latency: done expected DEPTH*(DATA_W+1) cycles after the start edge plus one cycle per stall.
// Backpressure: random and directed sout_ready stalls; held bits must not change.
module tb_regfile_reader;

    localparam int DW       = 4;
    localparam int AW       = 2;
    localparam int DP       = 4;
    localparam int WORD_CYC = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sout_ready = 1'b1;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          sout;
    logic          sout_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [DP];

    assign rdata = rf[raddr];

    regfile_reader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .raddr      (raddr),
        .rdata      (rdata),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int q[$];                 // expected transfers, encoded addr*2 + bit
    int starts_issued = 0;
    int dumps_done = 0;
    int start_cyc = 0;
    int idle_addr = 0;
    int xfer_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every transfer.
    bit   active = 1'b0;
    int   stalls = 0;
    bit   hold_pend = 1'b0;
    logic hold_val = 1'b0;
    int   target = 0;
    always @(negedge clk) begin : monitor
        int e;
        if (!rst_n) begin
            q.delete();
            dumps_done = starts_issued;
            active     = 1'b0;
            hold_pend  = 1'b0;
            idle_addr  = 0;
        end else begin
            if (!active && starts_issued != dumps_done) begin
                active = 1'b1;
                stalls = 0;
            end
            chk("busy", int'(busy), int'(active));
            if (!sout_valid) chk("sout_zero_when_invalid", int'(sout), 0);
            if (hold_pend) begin
                chk("hold_valid", int'(sout_valid), 1);
                chk("hold_sout", int'(sout), int'(hold_val));
            end
            hold_pend = 1'b0;
            if (sout_valid && !sout_ready) begin
                hold_pend = 1'b1;
                hold_val  = sout;
                stalls++;
            end
            if (sout_valid && sout_ready) begin
                xfer_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sout_bit", int'(sout), e & 1);
                    chk("raddr_during_word", int'(raddr), e >> 1);
                end
            end
            if (active) begin
                target = start_cyc + DP * WORD_CYC + stalls;
                if (done) begin
                    chk("done_cycle", cyc, target);
                    chk("done_after_all_bits", q.size(), 0);
                    active     = 1'b0;
                    dumps_done = starts_issued;
                    idle_addr  = DP - 1;
                end else if (cyc >= target) begin
                    chk("done_missing", 0, 1);
                    q.delete();
                    active     = 1'b0;
                    dumps_done = starts_issued;
                    idle_addr  = DP - 1;
                end
            end else begin
                chk("done_when_idle", int'(done), 0);
                chk("raddr_idle", int'(raddr), idle_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start for one edge while idle and queue the whole expected stream.
    task automatic issue_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        for (int w = 0; w < DP; w++)
            for (int b = DW - 1; b >= 0; b--)
                q.push_back(w * 2 + int'(rf[w][b]));
        starts_issued++;
    endtask

    task automatic run_dump(input bit rnd_ready, input bit rnd_start, input int stall_at);
        int  budget;
        int  base;
        bit  stalled;
        int  sw;
        int  sb;
        budget  = 0;
        stalled = 1'b0;
        base    = xfer_cnt;
        issue_start();
        while (starts_issued != dumps_done && budget < 400) begin
            sout_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
            start = rnd_start && (($urandom_range(3) == 0) || done);
            if (stall_at >= 0 && !stalled && xfer_cnt == base + stall_at) begin
                stalled    = 1'b1;
                sout_ready = 1'b0;
                sw = stall_at / DW;
                sb = DW - 1 - (stall_at % DW);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", int'(sout_valid), 1);
                    chk("stall_sout", int'(sout), int'(rf[sw][sb]));
                    tick();
                    budget++;
                end
            end else begin
                tick();
                budget++;
            end
        end
        start      = 1'b0;
        sout_ready = 1'b1;
        if (budget >= 400) chk("dump_timeout", 0, 1);
        repeat (3) tick();
    endtask

    task automatic check_reset_outputs();
        chk("rst_sout", int'(sout), 0);
        chk("rst_sout_valid", int'(sout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_raddr", int'(raddr), 0);
    endtask

    initial begin : stim
        int budget;
        int base;
        rf = '{4'b1111, 4'b0101, 4'b1101, 4'b0111};
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Full-rate dump of the preloaded file.
        run_dump(1'b0, 1'b0, -1);
        // Three-cycle stall while bit 2 of word 1 is presented.
        run_dump(1'b0, 1'b0, 5);
        // start re-pulsed during SHIFT and during DONE must be ignored.
        run_dump(1'b0, 1'b1, -1);

        // Reset in the middle of word 2 aborts the dump.
        budget = 0;
        base   = xfer_cnt;
        issue_start();
        while (xfer_cnt < base + 9 && budget < 200) begin
            tick();
            budget++;
        end
        if (budget >= 200) chk("reset_test_timeout", 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();
        run_dump(1'b0, 1'b0, -1);

        // Constant-data corner cases.
        for (int i = 0; i < DP; i++) rf[i] = 4'b0000;
        run_dump(1'b0, 1'b0, -1);
        for (int i = 0; i < DP; i++) rf[i] = 4'b1111;
        run_dump(1'b0, 1'b0, -1);

        // Random data, random backpressure, random spurious starts.
        repeat (20) begin
            for (int i = 0; i < DP; i++) rf[i] = DW'($urandom);
            run_dump(1'b1, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
